lzc_8_bit: RTL and testbench
============================

LZC_8_BIT -- requirements
Module: lzc_8_bit

Interface
REQ-001 Parameters: none; widths are fixed by constants in lzc_pkg.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, used only by the registered outputs.
REQ-004 rst  input  1  synchronous active-high reset, affects registered outputs only.
REQ-005 a  input  8  operand; bit 7 is the MSB, where counting starts.
REQ-006 Z  output  3  combinational leading-zero count of a.
REQ-007 V  output  1  combinational valid flag; 1 iff a contains at least one '1'.
REQ-008 Z_q  output  3  Z registered on clk.
REQ-009 V_q  output  1  V registered on clk.

Function
REQ-010 Z and V SHALL be purely combinational functions of a, with zero cycles latency and no dependence on clk or rst.
REQ-011 Z SHALL equal the number of consecutive '0' bits from a[7] downward before the first '1'. The range is 0..7.
REQ-012 V SHALL be 1 whenever a != 8'h00.
REQ-013 For a == 8'h00, the outputs SHALL be V=0 and Z=3'b111.
REQ-014 Outputs SHALL contain no X/Z for any fully-known a; they SHALL settle within one combinational delay of an input change.
REQ-015 Z_q/V_q SHALL capture Z/V on every rising clk edge, giving exactly 1-cycle latency. They have no enable.
REQ-016 The count SHALL use the hierarchical form:
- Split a into upper nibble a[7:4] and lower nibble a[3:0].
- Each nibble yields a 2-bit count and a valid flag.
- V = V_hi | V_lo.
- Z[2] = ~V_hi.
- Z[1:0] = V_hi ? Zhi : Zlo.

Reset
REQ-017 While rst=1 at a rising clk edge, Z_q SHALL be 3'b000 and V_q SHALL be 0 on the next cycle.
REQ-018 rst SHALL NOT affect Z or V.
REQ-019 When rst deasserts, Z_q/V_q SHALL reflect the Z/V sampled at the first edge with rst=0.
REQ-020 If rst asserts mid-stream, it SHALL override capture on that edge.

Structure
REQ-021 Package lzc_pkg SHALL hold:
- LZC_IN_W=8
- LZC_CNT_W=3
- LZC_NIB_W=4
- LZC_ZERO_CNT=3'b111
REQ-022 Sub-module lzc_4_bit SHALL be instantiated twice.
- Ports: 4-bit input, 2-bit count, valid.
- Internally built from 2-bit pair detectors.
- For an all-zero nibble it outputs count 2'b11 and valid 0.
REQ-023 The registered stage SHALL be a single always_ff block in lzc_8_bit.

Verification
REQ-024 Exhaustive sweep over all 256 values of a: Z/V checked against a reference count 1 time unit after each change, plus Z_q/V_q checked one cycle later.
REQ-025 a=8'b1000_0000 -> Z=000, V=1; a=8'b0000_0001 -> Z=111, V=1.
REQ-026 a=8'h00 -> Z=111, V=0; a=8'hFF -> Z=000, V=1.
REQ-027 Nibble boundary: a=8'b0001_0000 -> Z=011; a=8'b0000_1000 -> Z=100; a=8'b0010_1111 -> Z=010.
REQ-028 Reset test:
- Drive a=8'h01 with rst=1 for 2 edges -> Z_q=000, V_q=0 while Z=111, V=1.
- Deassert rst -> Z_q=111, V_q=1 after the next edge.
REQ-029 X-safety check: applying any known a -> neither Z nor V contains X.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared widths and constants for the 8-bit leading-zero counter.
package lzc_pkg;

  localparam int unsigned LZC_IN_W  = 8;
  localparam int unsigned LZC_CNT_W = 3;
  localparam int unsigned LZC_NIB_W = 4;

  localparam logic [LZC_CNT_W-1:0] LZC_ZERO_CNT = 3'b111;

  typedef logic [LZC_IN_W-1:0]  lzc_in_t;
  typedef logic [LZC_CNT_W-1:0] lzc_cnt_t;
  typedef logic [LZC_NIB_W-1:0] lzc_nib_t;

endpackage

// File: rtl/lzc_8_bit_if.sv
// Operand and result bundle for lzc_8_bit; the slave side is the counter.
interface lzc_8_bit_if;
  import lzc_pkg::*;

  lzc_in_t  a;
  lzc_cnt_t Z;
  logic     V;
  lzc_cnt_t Z_q;
  logic     V_q;

  modport master (output a, input Z, input V, input Z_q, input V_q);
  modport slave  (input a, output Z, output V, output Z_q, output V_q);

endinterface

// File: rtl/lzc_4_bit.sv
// Nibble leading-zero counter assembled from two 2-bit pair detectors.
module lzc_4_bit
  import lzc_pkg::*;
(
  input  lzc_nib_t   nib,
  output logic [1:0] cnt,
  output logic       vld
);

  // Pair detector: count is 1 when the upper bit is clear, which also
  // yields 1 for an empty pair so the all-zero nibble collapses to 2'b11.
  function automatic logic [1:0] pair_det(input logic [1:0] p);
    pair_det = {|p, ~p[1]};
  endfunction

  logic [1:0] hi_pair;
  logic [1:0] lo_pair;

  always_comb begin
    hi_pair = pair_det(nib[3:2]);
    lo_pair = pair_det(nib[1:0]);
    vld     = hi_pair[1] | lo_pair[1];
    cnt[1]  = ~hi_pair[1];
    cnt[0]  = hi_pair[1] ? hi_pair[0] : lo_pair[0];
  end

endmodule

// File: rtl/lzc_8_bit.sv
// 8-bit leading-zero counter: combinational Z/V plus a registered copy.
module lzc_8_bit
  import lzc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  lzc_8_bit_if.slave  bus
);

  logic [1:0] z_hi;
  logic [1:0] z_lo;
  logic       v_hi;
  logic       v_lo;
  lzc_cnt_t   z_comb;
  logic       v_comb;

  lzc_4_bit u_hi (
    .nib (bus.a[LZC_IN_W-1:LZC_NIB_W]),
    .cnt (z_hi),
    .vld (v_hi)
  );

  lzc_4_bit u_lo (
    .nib (bus.a[LZC_NIB_W-1:0]),
    .cnt (z_lo),
    .vld (v_lo)
  );

  // An empty upper nibble adds four zeros; the lower count fills the rest.
  always_comb begin
    v_comb = v_hi | v_lo;
    z_comb = {~v_hi, (v_hi ? z_hi : z_lo)};
  end

  assign bus.Z = z_comb;
  assign bus.V = v_comb;

  // Registered stage: one-cycle copy of Z/V, reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Z_q <= '0;
      bus.V_q <= 1'b0;
    end else begin
      bus.Z_q <= z_comb;
      bus.V_q <= v_comb;
    end
  end

endmodule

// File: tb/tb_lzc_8_bit.sv
// Self-checking bench for lzc_8_bit against a bit-scanning reference count.
module tb_lzc_8_bit;
  import lzc_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lzc_8_bit_if bus ();

  lzc_8_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_z(input logic [7:0] x);
    for (int b = 7; b >= 0; b--) begin
      if (x[b]) return 3'(7 - b);
    end
    return 3'd7;
  endfunction

  function automatic logic ref_v(input logic [7:0] x);
    return (x != 8'h00);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.a = 8'h01;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.Z_q !== 3'b000) begin
        errors++; $display("FAIL reset_zq edge%0d got=%b want=000", e, bus.Z_q);
      end
      checks++;
      if (bus.V_q !== 1'b0) begin
        errors++; $display("FAIL reset_vq edge%0d got=%b want=0", e, bus.V_q);
      end
      checks++;
      if (bus.Z !== 3'b111 || bus.V !== 1'b1) begin
        errors++; $display("FAIL reset_comb edge%0d got=%b/%b want=111/1", e, bus.Z, bus.V);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Z_q !== 3'b111 || bus.V_q !== 1'b1) begin
      errors++; $display("FAIL reset_release got=%b/%b want=111/1", bus.Z_q, bus.V_q);
    end
  endtask

  task automatic test_directed();
    logic [7:0] vec [8];
    logic [2:0] zexp [8];
    logic       vexp [8];
    vec = '{8'b1000_0000, 8'b0000_0001, 8'h00, 8'hFF,
            8'b0001_0000, 8'b0000_1000, 8'b0010_1111, 8'b0100_0000};
    zexp = '{3'b000, 3'b111, 3'b111, 3'b000, 3'b011, 3'b100, 3'b010, 3'b001};
    vexp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.a = vec[i];
      #1;
      checks++;
      if (bus.Z !== zexp[i] || bus.V !== vexp[i]) begin
        errors++;
        $display("FAIL directed a=%b got=%b/%b want=%b/%b", vec[i], bus.Z, bus.V, zexp[i], vexp[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] x;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      x = 8'(i);
      bus.a = x;
      #1;
      checks++;
      if (bus.Z !== ref_z(x) || bus.V !== ref_v(x)) begin
        errors++;
        $display("FAIL sweep_comb a=%h got=%b/%b want=%b/%b", x, bus.Z, bus.V, ref_z(x), ref_v(x));
      end
      checks++;
      if ($isunknown({bus.Z, bus.V})) begin
        errors++; $display("FAIL sweep_xsafe a=%h got=%b/%b want=known", x, bus.Z, bus.V);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.Z_q !== ref_z(x) || bus.V_q !== ref_v(x)) begin
        errors++;
        $display("FAIL sweep_reg a=%h got=%b/%b want=%b/%b", x, bus.Z_q, bus.V_q, ref_z(x), ref_v(x));
      end
    end
  endtask

  task automatic test_random_midstream_reset();
    logic [7:0] x;
    logic       r;
    logic [2:0] zq_exp;
    logic       vq_exp;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      x = 8'($urandom);
      // Bias toward sparse operands so low counts are not all that appears.
      if ($urandom_range(0, 2) == 0) x = x >> $urandom_range(0, 7);
      r = ($urandom_range(0, 7) == 0);
      bus.a = x;
      rst = r;
      zq_exp = r ? 3'b000 : ref_z(x);
      vq_exp = r ? 1'b0 : ref_v(x);
      #1;
      checks++;
      if (bus.Z !== ref_z(x) || bus.V !== ref_v(x)) begin
        errors++;
        $display("FAIL random_comb a=%h rst=%b got=%b/%b want=%b/%b", x, r, bus.Z, bus.V, ref_z(x), ref_v(x));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.Z_q !== zq_exp || bus.V_q !== vq_exp) begin
        errors++;
        $display("FAIL random_reg a=%h rst=%b got=%b/%b want=%b/%b", x, r, bus.Z_q, bus.V_q, zq_exp, vq_exp);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.a  = 8'h00;
    test_reset();
    test_directed();
    test_sweep();
    test_random_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
